// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the P5 fetch stage.
package fetch_stage_pkg;

   localparam logic [31:0] PC_RESET_DEF   = 32'h0000_3000;
   localparam int unsigned IMEM_DEPTH_DEF = 4096;
   localparam logic [31:0] NOP_INSTR_DEF  = 32'h0000_0000;

   localparam int unsigned WORD_W  = 32;
   localparam int unsigned SEL_W   = 2;
   localparam int unsigned IMM16_W = 16;
   localparam int unsigned IDX26_W = 26;

   // Next-PC source selected by the ID stage.
   typedef enum logic [SEL_W-1:0] {
      NPC_PC4 = 2'd0,
      NPC_BR  = 2'd1,
      NPC_J   = 2'd2,
      NPC_JR  = 2'd3
   } npc_sel_e;

   // IF/ID pipeline register payload.
   typedef struct packed {
      logic [WORD_W-1:0] instr;
      logic [WORD_W-1:0] pc;
      logic [WORD_W-1:0] pc8;
   } ifid_t;

   // Branch offset: sign-extended word offset converted to bytes.
   function automatic logic [WORD_W-1:0] br_offset(input logic [IMM16_W-1:0] imm);
      return {{(WORD_W-IMM16_W-2){imm[IMM16_W-1]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/fetch_stage_npc.sv
// Combinational next-PC selection; all redirect targets are relative to pc_d.
module fetch_stage_npc
   import fetch_stage_pkg::*;
(
   input  logic [WORD_W-1:0]  pc_f,
   input  logic [WORD_W-1:0]  pc_d,
   input  logic [SEL_W-1:0]   npc_sel,
   input  logic               br_taken,
   input  logic [IMM16_W-1:0] imm16_d,
   input  logic [IDX26_W-1:0] idx26_d,
   input  logic [WORD_W-1:0]  jr_target_d,
   output logic [WORD_W-1:0]  npc
);

   logic [WORD_W-1:0] pc4_f;
   logic [WORD_W-1:0] br_target;
   logic [WORD_W-1:0] j_target;

   assign pc4_f     = pc_f + 32'd4;
   assign br_target = pc_d + 32'd4 + br_offset(imm16_d);
   assign j_target  = {pc_d[31:28], idx26_d, 2'b00};

   // Select the redirect target; untaken branches fall through to pc_f+4.
   always_comb begin
      npc = pc4_f;
      case (npc_sel_e'(npc_sel))
         NPC_PC4: npc = pc4_f;
         NPC_BR:  npc = br_taken ? br_target : pc4_f;
         NPC_J:   npc = j_target;
         NPC_JR:  npc = jr_target_d;
         default: npc = pc4_f;
      endcase
   end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, instruction-memory addressing and IF/ID register.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] PC_RESET   = PC_RESET_DEF,
   parameter int unsigned IMEM_DEPTH = IMEM_DEPTH_DEF,
   parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEF
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          stall,
   input  logic                          flush_d,
   input  logic [SEL_W-1:0]              npc_sel,
   input  logic                          br_taken,
   input  logic [IMM16_W-1:0]            imm16_d,
   input  logic [IDX26_W-1:0]            idx26_d,
   input  logic [WORD_W-1:0]             jr_target_d,
   output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
   input  logic [WORD_W-1:0]             imem_rdata,
   output logic [WORD_W-1:0]             pc_f,
   output logic [WORD_W-1:0]             instr_d,
   output logic [WORD_W-1:0]             pc_d,
   output logic [WORD_W-1:0]             pc8_d,
   output logic                          addr_err_f
);

   localparam int unsigned ADDR_W   = $clog2(IMEM_DEPTH);
   localparam logic [32:0] PC_LIMIT = 33'(PC_RESET) + 33'(IMEM_DEPTH) * 33'd4;

   logic [WORD_W-1:0] npc;
   logic [WORD_W-1:0] pc_off;
   ifid_t             ifid_q;

   fetch_stage_npc u_npc (
      .pc_f        (pc_f),
      .pc_d        (ifid_q.pc),
      .npc_sel     (npc_sel),
      .br_taken    (br_taken),
      .imm16_d     (imm16_d),
      .idx26_d     (idx26_d),
      .jr_target_d (jr_target_d),
      .npc         (npc)
   );

   assign pc_off     = pc_f - PC_RESET;
   assign imem_addr  = ADDR_W'(pc_off >> 2);
   assign addr_err_f = (pc_f[1:0] != 2'b00) || (pc_f < PC_RESET) ||
                       ({1'b0, pc_f} >= PC_LIMIT);

   // PC and IF/ID update; stall holds everything and beats flush.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_f         <= PC_RESET;
         ifid_q.instr <= NOP_INSTR;
         ifid_q.pc    <= PC_RESET;
         ifid_q.pc8   <= PC_RESET + 32'd8;
      end else if (!stall) begin
         pc_f         <= npc;
         ifid_q.instr <= (flush_d || addr_err_f) ? NOP_INSTR : imem_rdata;
         ifid_q.pc    <= pc_f;
         ifid_q.pc8   <= pc_f + 32'd8;
      end
   end

   assign instr_d = ifid_q.instr;
   assign pc_d    = ifid_q.pc;
   assign pc8_d   = ifid_q.pc8;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational instruction memory.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        flush_d;
   logic [1:0]  npc_sel;
   logic        br_taken;
   logic [15:0] imm16_d;
   logic [25:0] idx26_d;
   logic [31:0] jr_target_d;
   logic [11:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] pc_f;
   logic [31:0] instr_d;
   logic [31:0] pc_d;
   logic [31:0] pc8_d;
   logic        addr_err_f;

   logic [31:0] mem [0:4095];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign imem_rdata = mem[imem_addr];

   fetch_stage dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .flush_d     (flush_d),
      .npc_sel     (npc_sel),
      .br_taken    (br_taken),
      .imm16_d     (imm16_d),
      .idx26_d     (idx26_d),
      .jr_target_d (jr_target_d),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .pc_f        (pc_f),
      .instr_d     (instr_d),
      .pc_d        (pc_d),
      .pc8_d       (pc8_d),
      .addr_err_f  (addr_err_f)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] sel, input logic bt, input logic st, input logic fl);
      npc_sel  = sel;
      br_taken = bt;
      stall    = st;
      flush_d  = fl;
   endtask

   task automatic chk_if_id(input string tag, input logic [31:0] e_pcf,
                            input logic [31:0] e_instr, input logic [31:0] e_pcd);
      check({tag, ".pc_f"}, pc_f, e_pcf);
      check({tag, ".instr_d"}, instr_d, e_instr);
      check({tag, ".pc_d"}, pc_d, e_pcd);
      check({tag, ".pc8_d"}, pc8_d, e_pcd + 32'd8);
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 32'hA000_0000 | 32'(i);
      mem[0] = 32'h3c01_0001;
      mem[1] = 32'h3421_0002;
      mem[2] = 32'h0000_0000;

      reset = 1'b0; imm16_d = '0; idx26_d = '0; jr_target_d = '0;
      drive(2'd0, 1'b0, 1'b0, 1'b0);
      tick(); tick();
      chk_if_id("reset", 32'h3000, 32'h0, 32'h3000);
      check("reset.imem_addr", 32'(imem_addr), 32'h0);
      check("reset.addr_err", 32'(addr_err_f), 32'h0);

      // free running fetch
      reset = 1'b1;
      tick();
      chk_if_id("run1", 32'h3004, 32'h3c01_0001, 32'h3000);
      tick();
      chk_if_id("run2", 32'h3008, 32'h3421_0002, 32'h3004);
      check("run2.imem_addr", 32'(imem_addr), 32'h2);

      // stall two cycles with a pending jump, then stall+flush
      idx26_d = 26'h000_0C40;
      drive(2'd2, 1'b0, 1'b1, 1'b0);
      tick(); tick();
      chk_if_id("stall2", 32'h3008, 32'h3421_0002, 32'h3004);
      drive(2'd2, 1'b0, 1'b1, 1'b1);
      tick();
      chk_if_id("stall_flush", 32'h3008, 32'h3421_0002, 32'h3004);
      drive(2'd2, 1'b0, 1'b0, 1'b0);
      tick();
      chk_if_id("jump_after_stall", 32'h3100, 32'h0, 32'h3008);

      // walk to pc_d = 0x3010 and take a backward branch
      jr_target_d = 32'h3010;
      drive(2'd3, 1'b0, 1'b0, 1'b0);
      tick();
      check("jr3010.pc_f", pc_f, 32'h3010);
      drive(2'd0, 1'b0, 1'b0, 1'b0);
      tick();
      chk_if_id("at3010", 32'h3014, 32'hA000_0004, 32'h3010);
      imm16_d = 16'hFFFC;
      drive(2'd1, 1'b1, 1'b0, 1'b0);
      tick();
      chk_if_id("beq_taken", 32'h3004, 32'hA000_0005, 32'h3014);

      // same branch not taken
      drive(2'd3, 1'b0, 1'b0, 1'b0);
      tick();
      drive(2'd0, 1'b0, 1'b0, 1'b0);
      tick();
      check("at3010b.pc_d", pc_d, 32'h3010);
      drive(2'd1, 1'b0, 1'b0, 1'b0);
      tick();
      chk_if_id("beq_not_taken", 32'h3018, 32'hA000_0005, 32'h3014);

      // jump from pc_d = 0x3020
      drive(2'd0, 1'b0, 1'b0, 1'b0);
      tick(); tick(); tick();
      check("at3020.pc_d", pc_d, 32'h3020);
      drive(2'd2, 1'b0, 1'b0, 1'b0);
      tick();
      chk_if_id("j", 32'h3100, 32'hA000_0009, 32'h3024);

      // jr to 0x3200
      jr_target_d = 32'h3200;
      drive(2'd3, 1'b0, 1'b0, 1'b0);
      tick();
      check("jr3200.pc_f", pc_f, 32'h3200);

      // flush alone inserts a bubble, pc advances
      drive(2'd0, 1'b0, 1'b0, 1'b1);
      tick();
      chk_if_id("flush", 32'h3204, 32'h0, 32'h3200);

      // misaligned jr target
      jr_target_d = 32'h3002;
      drive(2'd3, 1'b0, 1'b0, 1'b0);
      tick();
      check("mis.pc_f", pc_f, 32'h3002);
      check("mis.addr_err", 32'(addr_err_f), 32'h1);
      drive(2'd0, 1'b0, 1'b0, 1'b0);
      tick();
      chk_if_id("mis_nop", 32'h3006, 32'h0, 32'h3002);

      // below, at top, and above the instruction window
      jr_target_d = 32'h2FFC;
      drive(2'd3, 1'b0, 1'b0, 1'b0);
      tick();
      check("low.addr_err", 32'(addr_err_f), 32'h1);
      jr_target_d = 32'h6FFC;
      tick();
      check("top.addr_err", 32'(addr_err_f), 32'h0);
      check("top.imem_addr", 32'(imem_addr), 32'hFFF);
      jr_target_d = 32'h7000;
      tick();
      check("high.addr_err", 32'(addr_err_f), 32'h1);
      check("high.instr_d", instr_d, 32'hA000_0FFF);

      // reset during a stalled taken branch
      reset = 1'b0;
      drive(2'd1, 1'b1, 1'b1, 1'b0);
      tick();
      chk_if_id("reset_mid", 32'h3000, 32'h0, 32'h3000);
      reset = 1'b1;
      drive(2'd0, 1'b0, 1'b0, 1'b0);
      tick();
      chk_if_id("resume", 32'h3004, 32'h3c01_0001, 32'h3000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
